// File: rtl/mkio_transmitter.sv
// MIL-STD-1553 style Manchester word transmitter: 3-bit-time sync, 16 data bits
// MSB first and an odd parity bit, with a one-word holding register for gap-free chaining.
module mkio_transmitter #(
  parameter int HALF_BIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_ready,
  input  logic [15:0] tx_data,
  input  logic        tx_cd,
  output logic        tx_busy,
  output logic        tx_p,
  output logic        tx_n,
  output logic        tx_ovr
);

  typedef enum logic [1:0] {IDLE, SYNC, DATA, PARITY} state_t;

  state_t      state_r;
  logic [7:0]  cnt_r;
  logic [5:0]  half_r;
  logic [15:0] word_r;
  logic        cd_r;
  logic        par_r;
  logic [15:0] hold_data_r;
  logic        hold_cd_r;
  logic        hold_full_r;

  logic        half_end_s;
  logic        last_s;
  logic        slot_s;
  logic        start_s;
  logic        accept_s;
  logic [15:0] new_data_s;
  logic        new_cd_s;
  logic [5:0]  nxt_half_s;
  logic [3:0]  bit_idx_s;
  logic        step_pos_s;

  function automatic logic odd_parity(input logic [15:0] d);
    return ~^d;
  endfunction

  // Manchester: a 1 is positive-then-negative, a 0 is negative-then-positive
  function automatic logic bit_pos(input logic b, input logic first_half);
    return first_half ? b : ~b;
  endfunction

  // Word scheduling and the line level of the half-bit that follows the current one
  always_comb begin
    half_end_s = (cnt_r == 8'(HALF_BIT - 1));
    last_s     = (state_r == PARITY) && (half_r == 6'd1) && half_end_s;
    slot_s     = (state_r == IDLE) || last_s;
    start_s    = slot_s && (hold_full_r || tx_ready);
    accept_s   = !slot_s && !hold_full_r && tx_ready;
    new_data_s = hold_full_r ? hold_data_r : tx_data;
    new_cd_s   = hold_full_r ? hold_cd_r : tx_cd;
    nxt_half_s = half_r + 6'd1;
    bit_idx_s  = ~nxt_half_s[4:1];
    step_pos_s = 1'b0;
    case (state_r)
      SYNC: begin
        if (half_r == 6'd5) begin
          step_pos_s = bit_pos(word_r[15], 1'b1);
        end else begin
          step_pos_s = (nxt_half_s < 6'd3) ^ cd_r;
        end
      end
      DATA: begin
        if (half_r == 6'd31) begin
          step_pos_s = bit_pos(par_r, 1'b1);
        end else begin
          step_pos_s = bit_pos(word_r[bit_idx_s], ~nxt_half_s[0]);
        end
      end
      PARITY:  step_pos_s = bit_pos(par_r, 1'b0);
      default: step_pos_s = 1'b0;
    endcase
  end

  // Transmit FSM, holding register and registered line outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      cnt_r       <= 8'd0;
      half_r      <= 6'd0;
      word_r      <= 16'd0;
      cd_r        <= 1'b0;
      par_r       <= 1'b0;
      hold_data_r <= 16'd0;
      hold_cd_r   <= 1'b0;
      hold_full_r <= 1'b0;
      tx_busy     <= 1'b0;
      tx_p        <= 1'b0;
      tx_n        <= 1'b0;
      tx_ovr      <= 1'b0;
    end else begin
      tx_ovr <= tx_ready && hold_full_r;
      if (accept_s) begin
        hold_data_r <= tx_data;
        hold_cd_r   <= tx_cd;
        hold_full_r <= 1'b1;
      end else if (start_s && hold_full_r) begin
        hold_full_r <= 1'b0;
      end
      if (start_s) begin
        state_r <= SYNC;
        cnt_r   <= 8'd0;
        half_r  <= 6'd0;
        word_r  <= new_data_s;
        cd_r    <= new_cd_s;
        par_r   <= odd_parity(new_data_s);
        tx_busy <= 1'b1;
        tx_p    <= ~new_cd_s;
        tx_n    <= new_cd_s;
      end else if (state_r == IDLE) begin
        cnt_r   <= 8'd0;
        half_r  <= 6'd0;
        tx_busy <= 1'b0;
        tx_p    <= 1'b0;
        tx_n    <= 1'b0;
      end else if (!half_end_s) begin
        cnt_r <= cnt_r + 8'd1;
      end else begin
        cnt_r <= 8'd0;
        tx_p  <= step_pos_s;
        tx_n  <= ~step_pos_s;
        case (state_r)
          SYNC: begin
            if (half_r == 6'd5) begin
              state_r <= DATA;
              half_r  <= 6'd0;
            end else begin
              half_r <= nxt_half_s;
            end
          end
          DATA: begin
            if (half_r == 6'd31) begin
              state_r <= PARITY;
              half_r  <= 6'd0;
            end else begin
              half_r <= nxt_half_s;
            end
          end
          PARITY: begin
            if (half_r == 6'd1) begin
              state_r <= IDLE;
              half_r  <= 6'd0;
              tx_busy <= 1'b0;
              tx_p    <= 1'b0;
              tx_n    <= 1'b0;
            end else begin
              half_r <= nxt_half_s;
            end
          end
          default: begin
            state_r <= IDLE;
            half_r  <= 6'd0;
            tx_busy <= 1'b0;
            tx_p    <= 1'b0;
            tx_n    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
